// File: rtl/tt_slot_wrapper.sv
// Project-slot wrapper: unpacks mux bus to project pins, sequences
// enable/reset-hold, isolates outputs unless running.
module tt_slot_wrapper #(
  parameter int UI_W     = 8,
  parameter int UO_W     = 8,
  parameter int UIO_W    = 8,
  parameter int RST_HOLD = 4,
  parameter int IN_REG   = 1,
  parameter int OUT_REG  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [UIO_W+UI_W:0]       iw,
  output logic [2*UIO_W+UO_W-1:0]   ow,
  output logic                      proj_ena,
  output logic                      proj_rst_n,
  output logic [UI_W-1:0]           proj_ui_in,
  output logic [UIO_W-1:0]          proj_uio_in,
  input  logic [UO_W-1:0]           proj_uo_out,
  input  logic [UIO_W-1:0]          proj_uio_out,
  input  logic [UIO_W-1:0]          proj_uio_oe,
  output logic [1:0]                slot_state
);

  localparam int IW_W = UIO_W + UI_W + 1;
  localparam int OW_W = 2*UIO_W + UO_W;
  localparam int CW   = $clog2(RST_HOLD) + 1;

  localparam logic [1:0] OFF  = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam logic [CW-1:0] LOAD = CW'(RST_HOLD - 1);

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [IW_W-1:0] iw_eff;
  logic [OW_W-1:0] packed_o;
  logic            req_n;

  generate
    if (IN_REG != 0) begin : g_in_reg
      logic [IW_W-1:0] iw_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      iw_q <= '0;
        else if (ena) iw_q <= iw;
        else          iw_q <= '0;
      end
      assign iw_eff = iw_q;
    end else begin : g_in_comb
      assign iw_eff = (state == OFF) ? '0 : iw;
    end
  endgenerate

  assign req_n       = iw_eff[0];
  assign proj_ui_in  = iw_eff[UI_W:1];
  assign proj_uio_in = iw_eff[IW_W-1:UI_W+1];

  // ena outranks everything; a low rst_n_req restarts the hold window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF;
      cnt   <= '0;
    end else if (!ena) begin
      state <= OFF;
      cnt   <= '0;
    end else if (state == OFF) begin
      state <= HOLD;
      cnt   <= LOAD;
    end else if (state == HOLD) begin
      if (!req_n) begin
        cnt <= LOAD;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        state <= RUN;
      end
    end else if (state == RUN) begin
      if (!req_n) begin
        state <= HOLD;
        cnt   <= LOAD;
      end
    end else begin
      state <= OFF;
      cnt   <= '0;
    end
  end

  assign proj_ena   = (state != OFF);
  assign proj_rst_n = (state == RUN);
  assign slot_state = state;

  assign packed_o = (state == RUN) ?
    {proj_uio_oe, proj_uio_out, proj_uo_out} : '0;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [OW_W-1:0] ow_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) ow_q <= '0;
        else     ow_q <= packed_o;
      end
      assign ow = ow_q;
    end else begin : g_out_comb
      assign ow = packed_o;
    end
  endgenerate

endmodule
